// File: rtl/bus_ram.sv
// bus_ram: read/write data memory on the shared tristate system bus.
// It uses the same MAR/MDR strobes as the program ROM and occupies the half
// of the address space where mar[ADDR_W-1] == REGION.
// An access starts when CS is high in IDLE and the region is hit.
// The access completes WAIT_CYCLES edges later, or on the start edge itself
// when WAIT_CYCLES is 0.
//
// Ports:
//   clock      system clock, rising edge
//   n_reset    asynchronous active-low reset
//   MDR_bus    drive mdr onto sysbus (only when hit and idle)
//   load_MDR   latch sysbus into mdr (ignored while busy)
//   load_MAR   latch sysbus[ADDR_W-1:0] into mar (any state)
//   CS         start an access (qualified by region hit)
//   R_NW       1 = read, 0 = write, sampled with CS
//   sysbus     shared WORD_W-bit tristate bus
//   acc_err    sticky misuse flag (only with BUS_RAM_ERR_EN defined)
//   mem_ready  1 = idle and able to accept CS
//
// Optional feature macro: BUS_RAM_ERR_EN adds the acc_err output. The flag is
// set by CS while busy, or by CS that misses the region while load_MAR is low.
//
// State table:
//   IDLE | no access in flight; mdr loadable; CS & hit starts an access
//   BUSY | access in flight; counter runs down to the completion edge

module bus_ram #(
  parameter int WORD_W      = 8,
  parameter int OP_W        = 3,
  parameter int REGION      = 1,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clock,
  input  logic              n_reset,
  input  logic              MDR_bus,
  input  logic              load_MDR,
  input  logic              load_MAR,
  input  logic              CS,
  input  logic              R_NW,
  inout  wire  [WORD_W-1:0] sysbus,
`ifdef BUS_RAM_ERR_EN
  output logic              acc_err,
`endif
  output logic              mem_ready
);

  localparam int ADDR_W = WORD_W - OP_W;
  localparam int IDX_W  = ADDR_W - 1;
  localparam int DEPTH  = 2 ** IDX_W;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state;
  logic [ADDR_W-1:0] mar;
  logic [WORD_W-1:0] mdr;
  logic [IDX_W-1:0]  acc_addr;
  logic              acc_rd;
  logic [3:0]        wait_cnt;
  logic [WORD_W-1:0] mem [DEPTH];

  logic             hit;
  logic             start;
  logic             complete;
  logic [IDX_W-1:0] cmp_addr;
  logic             cmp_rd;
  logic             wr_en;

  assign hit   = (mar[ADDR_W-1] == 1'(REGION));
  assign start = (state == IDLE) && CS && hit;

  // With zero latency the access completes on its own start edge, so the
  // address and direction come straight from mar/R_NW instead of the snapshot.
  always_comb begin
    complete = 1'b0;
    cmp_addr = acc_addr;
    cmp_rd   = acc_rd;
    if (WAIT_CYCLES == 0) begin
      complete = start;
      cmp_addr = mar[IDX_W-1:0];
      cmp_rd   = R_NW;
    end else begin
      complete = (state == BUSY) && (wait_cnt == 4'd1);
    end
  end

  // An edge that arrives while reset is held must never commit a write.
  assign wr_en = complete && !cmp_rd && n_reset;

  assign sysbus = (MDR_bus && hit && mem_ready) ? mdr : {WORD_W{1'bz}};

  always_ff @(posedge clock) begin
    if (wr_en) mem[cmp_addr] <= mdr;
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state     <= IDLE;
      mar       <= '0;
      mdr       <= '0;
      acc_addr  <= '0;
      acc_rd    <= 1'b0;
      wait_cnt  <= '0;
      mem_ready <= 1'b1;
    end else begin
      if (load_MAR) mar <= sysbus[ADDR_W-1:0];

      // Read data has priority over a simultaneous load_MDR.
      if (complete && cmp_rd)
        mdr <= mem[cmp_addr];
      else if (load_MDR && state == IDLE)
        mdr <= sysbus;

      case (state)
        IDLE: begin
          if (start) begin
            acc_addr <= mar[IDX_W-1:0];
            acc_rd   <= R_NW;
            if (WAIT_CYCLES != 0) begin
              wait_cnt  <= WAIT_INIT;
              state     <= BUSY;
              mem_ready <= 1'b0;
            end
          end
        end
        BUSY: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) begin
            state     <= IDLE;
            mem_ready <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          mem_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef BUS_RAM_ERR_EN
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset)
      acc_err <= 1'b0;
    else if ((CS && state == BUSY) || (CS && !hit && !load_MAR))
      acc_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_bus_ram.sv
// Scoreboard bench for bus_ram.
// Five instances are built with different latencies: 0, 1, 3, 4 and 7.
// Each instance has its own pulled-up bus, so a released bus reads back as 8'hFF.
// Stimulus pushes the expected bus read-back values and the expected mem_ready
// low durations into queues. A monitor pops and compares them at the falling
// edge, whenever a read-back is presented or mem_ready returns high.
module tb_bus_ram;

  localparam int NI = 5;
  localparam int WAITS [NI] = '{0, 1, 3, 4, 7};

  logic clock = 1'b0;
  logic n_reset = 1'b0;
  always #5 clock = ~clock;

  logic       mdr_bus  [NI];
  logic       load_mdr [NI];
  logic       load_mar [NI];
  logic       cs       [NI];
  logic       r_nw     [NI];
  logic       drv_en   [NI];
  logic [7:0] drv_val  [NI];
  logic       ready    [NI];
  logic [7:0] bus_obs  [NI];
`ifdef BUS_RAM_ERR_EN
  logic       err      [NI];
`endif

  for (genvar g = 0; g < NI; g++) begin : gi
    tri1 [7:0] sysbus;
    assign sysbus = drv_en[g] ? drv_val[g] : 8'bz;
    assign bus_obs[g] = sysbus;
    bus_ram #(.WAIT_CYCLES(WAITS[g])) dut (
      .clock     (clock),
      .n_reset   (n_reset),
      .MDR_bus   (mdr_bus[g]),
      .load_MDR  (load_mdr[g]),
      .load_MAR  (load_mar[g]),
      .CS        (cs[g]),
      .R_NW      (r_nw[g]),
      .sysbus    (sysbus),
`ifdef BUS_RAM_ERR_EN
      .acc_err   (err[g]),
`endif
      .mem_ready (ready[g])
    );
  end

  typedef struct { int k; logic [7:0] exp; string name; } rd_t;
  typedef struct { int k; int n; } lat_t;
  rd_t  rd_q  [$];
  lat_t lat_q [$];
  int checks = 0;
  int errors = 0;
  int low_cnt [NI];

  function automatic void check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  // Monitor: compares whatever the DUTs present against the queues.
  initial begin
    rd_t  re;
    lat_t le;
    for (int k = 0; k < NI; k++) low_cnt[k] = 0;
    forever begin
      @(negedge clock or negedge n_reset);
      if (!n_reset) begin
        for (int k = 0; k < NI; k++) low_cnt[k] = 0;
      end else begin
        for (int k = 0; k < NI; k++) begin
          if (!ready[k]) begin
            low_cnt[k]++;
          end else if (low_cnt[k] != 0) begin
            if (lat_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL ready_low_i%0d: got %0d busy cycles, expected none", k, low_cnt[k]);
            end else begin
              le = lat_q.pop_front();
              check($sformatf("ready_low_inst_i%0d", k), k, le.k);
              check($sformatf("ready_low_i%0d", k), low_cnt[k], le.n);
            end
            low_cnt[k] = 0;
          end
          if (mdr_bus[k] && ready[k]) begin
            if (rd_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL readback_i%0d: got %0h, expected no read-back", k, bus_obs[k]);
            end else begin
              re = rd_q.pop_front();
              check($sformatf("%s_inst", re.name), k, re.k);
              check(re.name, int'(bus_obs[k]), int'(re.exp));
            end
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic ld_mar(int k, logic [7:0] a);
    drv_en[k] = 1'b1; drv_val[k] = a; load_mar[k] = 1'b1;
    step();
    load_mar[k] = 1'b0; drv_en[k] = 1'b0;
  endtask

  task automatic ld_mdr(int k, logic [7:0] d);
    drv_en[k] = 1'b1; drv_val[k] = d; load_mdr[k] = 1'b1;
    step();
    load_mdr[k] = 1'b0; drv_en[k] = 1'b0;
  endtask

  task automatic wait_ready(int k);
    int n = 0;
    while (!ready[k] && n < 50) begin
      step();
      n++;
    end
    if (!ready[k]) begin
      checks++;
      errors++;
      $display("FAIL wait_ready_i%0d: got mem_ready 0 after 50 cycles, expected 1", k);
    end
  endtask

  task automatic access(int k, logic rd);
    lat_t le;
    if (WAITS[k] > 0) begin
      le.k = k; le.n = WAITS[k];
      lat_q.push_back(le);
    end
    cs[k] = 1'b1; r_nw[k] = rd;
    step();
    cs[k] = 1'b0;
    wait_ready(k);
  endtask

  task automatic readback(int k, logic [7:0] exp, string name);
    rd_t re;
    re.k = k; re.exp = exp; re.name = name;
    rd_q.push_back(re);
    mdr_bus[k] = 1'b1;
    step();
    mdr_bus[k] = 1'b0;
  endtask

  task automatic wr(int k, logic [7:0] a, logic [7:0] d);
    ld_mar(k, a);
    ld_mdr(k, d);
    access(k, 1'b0);
  endtask

  task automatic rd_chk(int k, logic [7:0] a, logic [7:0] exp, string name);
    ld_mar(k, a);
    ld_mdr(k, 8'h00);
    access(k, 1'b1);
    readback(k, exp, name);
  endtask

  initial begin
    lat_t le;
    for (int k = 0; k < NI; k++) begin
      mdr_bus[k] = 0; load_mdr[k] = 0; load_mar[k] = 0;
      cs[k] = 0; r_nw[k] = 0; drv_en[k] = 0; drv_val[k] = '0;
    end
    n_reset = 1'b0;
    step(); step();
    for (int k = 0; k < NI; k++) check($sformatf("reset_ready_i%0d", k), int'(ready[k]), 1);
    n_reset = 1'b1;
    step();

    // Write then read back at latency 1.
    wr(1, 8'd30, 8'hA5);
    rd_chk(1, 8'd30, 8'hA5, "w1_rw_30");

    // Latency sweep on address 31.
    foreach (WAITS[k]) begin
      if (k == 0 || k == 2 || k == 4) begin
        wr(k, 8'd31, 8'h3C);
        rd_chk(k, 8'd31, 8'h3C, $sformatf("sweep_w%0d", WAITS[k]));
      end
    end

    // Zero latency: read CS with load_MDR on the same edge -> read data wins.
    ld_mar(0, 8'd31);
    ld_mdr(0, 8'h00);
    cs[0] = 1'b1; r_nw[0] = 1'b1; drv_en[0] = 1'b1; drv_val[0] = 8'h99; load_mdr[0] = 1'b1;
    step();
    cs[0] = 1'b0; drv_en[0] = 1'b0; load_mdr[0] = 1'b0;
    readback(0, 8'h3C, "w0_rd_beats_ldmdr");
    // Zero latency: write CS with load_MDR -> mem gets old mdr, mdr gets bus.
    ld_mar(0, 8'd29);
    ld_mdr(0, 8'h44);
    cs[0] = 1'b1; r_nw[0] = 1'b0; drv_en[0] = 1'b1; drv_val[0] = 8'h55; load_mdr[0] = 1'b1;
    step();
    cs[0] = 1'b0; drv_en[0] = 1'b0; load_mdr[0] = 1'b0;
    readback(0, 8'h55, "w0_wr_mdr_new");
    rd_chk(0, 8'd29, 8'h44, "w0_wr_mem_old");

    // Region miss: mar=5 aliases index 5 (address 21) but must not touch it.
    wr(1, 8'd21, 8'h6B);
    ld_mar(1, 8'd5);
    ld_mdr(1, 8'hFF);
    cs[1] = 1'b1; r_nw[1] = 1'b0;
    step();
    cs[1] = 1'b0;
    check("miss_ready_a", int'(ready[1]), 1);
    step();
    check("miss_ready_b", int'(ready[1]), 1);
    ld_mdr(1, 8'h5A);
    readback(1, 8'hFF, "miss_bus_released");
`ifdef BUS_RAM_ERR_EN
    check("miss_acc_err", int'(err[1]), 1);
    check("clean_acc_err_i0", int'(err[0]), 0);
`endif
    rd_chk(1, 8'd21, 8'h6B, "miss_mem21");

    // Busy interference at latency 3.
    wr(2, 8'd18, 8'h99);
    ld_mar(2, 8'd17);
    ld_mdr(2, 8'h11);
    le.k = 2; le.n = 3;
    lat_q.push_back(le);
    cs[2] = 1'b1; r_nw[2] = 1'b0;
    step();
    cs[2] = 1'b0; drv_en[2] = 1'b1; drv_val[2] = 8'd18; load_mar[2] = 1'b1;
    step();
    load_mar[2] = 1'b0; drv_val[2] = 8'h22; load_mdr[2] = 1'b1; cs[2] = 1'b1;
    step();
    cs[2] = 1'b0; drv_en[2] = 1'b0; load_mdr[2] = 1'b0;
    wait_ready(2);
    readback(2, 8'h11, "busy_mdr_frozen");
`ifdef BUS_RAM_ERR_EN
    check("busy_acc_err", int'(err[2]), 1);
`endif
    rd_chk(2, 8'd17, 8'h11, "busy_mem17");
    rd_chk(2, 8'd18, 8'h99, "busy_mem18");

    // Reset mid-write at latency 4.
    wr(3, 8'd20, 8'h00);
    ld_mdr(3, 8'h77);
    cs[3] = 1'b1; r_nw[3] = 1'b0;
    step();
    cs[3] = 1'b0;
    step();
    step();
    check("rst_busy_before", int'(ready[3]), 0);
    n_reset = 1'b0;
    #1;
    check("rst_ready_immediate", int'(ready[3]), 1);
    #1;
    n_reset = 1'b1;
`ifdef BUS_RAM_ERR_EN
    check("rst_acc_err_i1", int'(err[1]), 0);
    check("rst_acc_err_i2", int'(err[2]), 0);
`endif
    step();
    readback(1, 8'hFF, "rst_mar0_bus_released");
    ld_mar(3, 8'd16);
    readback(3, 8'h00, "rst_mdr_zero");
    rd_chk(3, 8'd20, 8'h00, "rst_write_abandoned");

    step(); step();
    check("rd_queue_drained", rd_q.size(), 0);
    check("lat_queue_drained", lat_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
